// File: rtl/reg_set_arbiter.sv
`default_nettype none
// ============================================================================
// reg_set_arbiter
// Round-robin arbitration of two valid/ready write requesters onto a pair of
// storage registers. A capture cycle is followed by a commit cycle.
// Optional requester locking is enabled with ARB_LOCK_EN.
// Revision: 1.0
// ============================================================================
module reg_set_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
`ifdef ARB_LOCK_EN
  input  logic              req0_lock,
  input  logic              req1_lock,
`endif
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic              wr_done,
  output logic              wr_src
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ptr;
  logic              r_hold_addr;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_hold_src;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer;
  logic              w_win;
  logic              w_lock;
  logic              w_owner;
  logic              w_own_active;

`ifdef ARB_LOCK_EN
  logic r_owned;
  logic r_owner;

  assign w_owner      = r_owner;
  // Ownership only blocks the other side while the owner is still asking.
  assign w_own_active = r_owned && (r_owner ? req1_valid : req0_valid);
  assign w_lock       = w_win ? req1_lock : req0_lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owned <= 1'b0;
      r_owner <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_xfer) begin
        r_owned <= w_lock;
        r_owner <= w_win;
      end else if (r_owned && !w_own_active) begin
        r_owned <= 1'b0;
      end
    end
  end
`else
  assign w_owner      = 1'b0;
  assign w_own_active = 1'b0;
  assign w_lock       = 1'b0;
`endif

  assign w_xfer     = w_gnt0 | w_gnt1;
  assign w_win      = w_gnt1;
  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_own_active) begin
            w_gnt0 = !w_owner;
            w_gnt1 = w_owner;
          end else if (req0_valid && req1_valid) begin
            w_gnt0 = !r_ptr;
            w_gnt1 = r_ptr;
          end else begin
            w_gnt0 = req0_valid;
            w_gnt1 = req1_valid;
          end
          if (w_gnt0 || w_gnt1) begin
            w_state_nxt = S_WRITE;
          end
        end
        S_WRITE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= 1'b0;
      r_hold_addr <= 1'b0;
      r_hold_data <= '0;
      r_hold_src  <= 1'b0;
      q0          <= '0;
      q1          <= '0;
      wr_done     <= 1'b0;
      wr_src      <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_hold_addr <= w_win ? req1_addr : req0_addr;
            r_hold_data <= w_win ? req1_data : req0_data;
            r_hold_src  <= w_win;
            // A locked transfer keeps priority where it is.
            if (!w_lock) begin
              r_ptr <= ~w_win;
            end
          end
        end
        S_WRITE: begin
          if (r_hold_addr) begin
            q1 <= r_hold_data;
          end else begin
            q0 <= r_hold_data;
          end
          wr_done <= 1'b1;
          wr_src  <= r_hold_src;
        end
        default: begin
          wr_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_set_arbiter.sv
`default_nettype none
// ============================================================================
// tb_reg_set_arbiter
// Directed scenarios plus randomized traffic against a transaction-level model.
// Revision: 1.0
// ============================================================================
module tb_reg_set_arbiter;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              vld [2];
  logic              adr [2];
  logic [DATA_W-1:0] dat [2];
  logic              lck [2];
  logic              rdy0, rdy1;
  logic [DATA_W-1:0] q0, q1;
  logic              wr_done, wr_src;

  always #5 clk = ~clk;

  reg_set_arbiter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(vld[0]),
    .req0_addr (adr[0]),
    .req0_data (dat[0]),
    .req0_ready(rdy0),
    .req1_valid(vld[1]),
    .req1_addr (adr[1]),
    .req1_data (dat[1]),
    .req1_ready(rdy1),
`ifdef ARB_LOCK_EN
    .req0_lock (lck[0]),
    .req1_lock (lck[1]),
`endif
    .q0        (q0),
    .q1        (q1),
    .wr_done   (wr_done),
    .wr_src    (wr_src)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: register contents, one outstanding write, tie-break preference
  logic [DATA_W-1:0] m_reg [2];
  bit                m_busy;
  int                m_paddr, m_psrc;
  logic [DATA_W-1:0] m_pdata;
  int                m_pref;
  bit                m_done;
  int                m_dsrc;
  bit                m_own;
  int                m_owner;
  bit                g_acc [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_rdy(input int n);
    if (rst || m_busy || !vld[n]) return 1'b0;
    if (m_own && vld[m_owner]) return n == m_owner;
    if (vld[1-n]) return m_pref == n;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_reg[0] = '0; m_reg[1] = '0;
    m_busy = 0; m_paddr = 0; m_psrc = 0; m_pdata = '0;
    m_pref = 0; m_done = 0; m_dsrc = 0; m_own = 0; m_owner = 0;
  endtask

  // One clock: check outputs mid-cycle, advance model across the edge.
  task automatic step();
    bit e0, e1, r;
    int w;
    @(negedge clk);
    e0 = exp_rdy(0);
    e1 = exp_rdy(1);
    check("req0_ready", {31'd0, rdy0}, {31'd0, e0});
    check("req1_ready", {31'd0, rdy1}, {31'd0, e1});
    check("q0", {24'd0, q0}, {24'd0, m_reg[0]});
    check("q1", {24'd0, q1}, {24'd0, m_reg[1]});
    check("wr_done", {31'd0, wr_done}, {31'd0, m_done});
    if (m_done) check("wr_src", {31'd0, wr_src}, m_dsrc);
    g_acc[0] = e0;
    g_acc[1] = e1;
    r = rst;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_reg[m_paddr] = m_pdata;
        m_done = 1;
        m_dsrc = m_psrc;
        m_busy = 0;
      end else if (e0 || e1) begin
        w = e0 ? 0 : 1;
        m_paddr = int'(adr[w]);
        m_pdata = dat[w];
        m_psrc  = w;
        m_busy  = 1;
        if (lck[w]) begin
          m_own = 1;
          m_owner = w;
        end else begin
          m_own = 0;
          m_pref = 1 - w;
        end
      end else if (m_own && !vld[m_owner]) begin
        m_own = 0;
      end
    end
    #1;
  endtask

  task automatic step_drop(input int k);
    for (int i = 0; i < k; i++) begin
      step();
      for (int n = 0; n < 2; n++) if (g_acc[n]) vld[n] = 1'b0;
    end
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      vld[n] = 1'b0; adr[n] = 1'b0; dat[n] = '0; lck[n] = 1'b0;
    end
    model_reset();

    // Reset held for two cycles with nothing pending
    rst = 1'b1;
    step_drop(2);
    rst = 1'b0;
    step_drop(2);

    // Single write from requester 0 into q1
    vld[0] = 1'b1; adr[0] = 1'b1; dat[0] = 8'hA5;
    step_drop(4);

    // Contention from reset: grants alternate, fresh data after each accept
    rst = 1'b1;
    step_drop(1);
    rst = 1'b0;
    vld[0] = 1'b1; adr[0] = 1'b0; dat[0] = 8'h11;
    vld[1] = 1'b1; adr[1] = 1'b1; dat[1] = 8'h22;
    for (int i = 0; i < 10; i++) begin
      step();
      for (int n = 0; n < 2; n++) if (g_acc[n]) dat[n] = dat[n] + 8'h01;
    end
    vld[0] = 1'b0; vld[1] = 1'b0;
    step_drop(2);

    // Same-register overwrite by the other requester
    vld[0] = 1'b1; adr[0] = 1'b0; dat[0] = 8'h33;
    step_drop(3);
    vld[1] = 1'b1; adr[1] = 1'b0; dat[1] = 8'h44;
    step_drop(3);

    // Reset during the commit cycle discards the write
    vld[1] = 1'b1; adr[1] = 1'b0; dat[1] = 8'h7E;
    step_drop(1);
    rst = 1'b1;
    step_drop(1);
    rst = 1'b0;
    vld[0] = 1'b1; adr[0] = 1'b1; dat[0] = 8'h5A;
    vld[1] = 1'b1; adr[1] = 1'b0; dat[1] = 8'hC3;
    step_drop(6);

`ifdef ARB_LOCK_EN
    // Requester 0 holds the lock for three transfers while requester 1 waits
    begin
      int cnt = 0;
      vld[0] = 1'b1; adr[0] = 1'b0; dat[0] = 8'h01; lck[0] = 1'b1;
      vld[1] = 1'b1; adr[1] = 1'b1; dat[1] = 8'h90; lck[1] = 1'b0;
      for (int i = 0; i < 14; i++) begin
        step();
        if (g_acc[0]) begin
          cnt++;
          dat[0] = dat[0] + 8'h01;
          lck[0] = (cnt < 3);
        end
        if (g_acc[1]) vld[1] = 1'b0;
      end
      vld[0] = 1'b0; vld[1] = 1'b0; lck[0] = 1'b0;
      step_drop(2);
    end
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step();
      rst = ($urandom_range(0, 49) == 0);
      for (int n = 0; n < 2; n++) begin
        if (g_acc[n] || !vld[n]) begin
          vld[n] = ($urandom_range(0, 2) != 0);
          adr[n] = 1'($urandom_range(0, 1));
          dat[n] = 8'($urandom);
`ifdef ARB_LOCK_EN
          lck[n] = ($urandom_range(0, 2) == 0);
`endif
        end
      end
    end
    rst = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0;
    step_drop(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_set_arbiter.md
Name: reg_set_arbiter

Overview:
- Shares a pair of DATA_W-bit storage registers between two independent write requesters.
- Each requester uses a valid/ready handshake. A round-robin arbiter picks one winner per arbitration.
- A two-state sequencer captures the winning address/data, then commits it to the addressed register.
- Sits between bus-side masters and the register storage; the register contents are exported continuously.

Parameters:
- DATA_W, 8, width of each register and each write data bus.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  1  requester 0 target: 0 = q0, 1 = q1.
- req0_data  input  DATA_W  requester 0 write data.
- req0_ready  output  1  requester 0 transfer accepted this cycle.
- req1_valid  input  1  requester 1 has a write pending.
- req1_addr  input  1  requester 1 target register.
- req1_data  input  DATA_W  requester 1 write data.
- req1_ready  output  1  requester 1 transfer accepted this cycle.
- q0  output  DATA_W  register 0 contents.
- q1  output  DATA_W  register 1 contents.
- wr_done  output  1  one-cycle pulse: a register was written at the last edge.
- wr_src  output  1  requester whose write completed; valid when wr_done=1.

Behaviour:
- Reset values: q0=0, q1=0, wr_done=0, wr_src=0, state=IDLE, priority pointer=requester 0, holding regs=0. req0_ready=req1_ready=0 while rst=1.
- Handshake: a transfer occurs on a rising edge where reqN_valid=1 and reqN_ready=1.
  - Requesters hold valid/addr/data stable until accepted. Valid must not depend on ready.
  - ready is combinational from valid, state and pointer.
- FSM state IDLE:
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester named by the pointer gets ready=1; the other gets 0.
  - No valid: both ready=0.
  - On a transfer: latch addr, data and source into holding regs; pointer := the other requester; go to WRITE.
- FSM state WRITE:
  - Both ready=0.
  - At the edge: holding data is written to q0 or q1 per holding addr; wr_done=1 and wr_src=source in the following cycle; return to IDLE.
- Latency: accepted at edge N, q visible and wr_done=1 after edge N+1.
- Throughput: at most one write per 2 cycles.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1.
- Non-targeted register is unchanged.
- Back-to-back writes to the same register from different requesters: the later grant overwrites the earlier. No merging.
- wr_done is 0 in every cycle not immediately following a WRITE edge.
- Reset in WRITE: the pending write is discarded (q0/q1 go to 0), no wr_done pulse, FSM returns to IDLE.
- Reset in the same cycle as valid: no transfer; ready=0.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds inputs req0_lock and req1_lock (1 bit each), sampled with the transfer.
  - A transfer with lock=1 makes that requester owner: the pointer is not rotated, and the other requester's ready is forced to 0 in subsequent IDLE cycles.
  - Ownership is released by an owner transfer with lock=0 (pointer then rotates normally), or by the owner having valid=0 in an IDLE cycle.
  - Ownership is cleared by reset.
- Undefined: no lock ports; pure round-robin as above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no valid -> q0=q1=0, ready both 0, wr_done=0 throughout.
- Single write: req0 valid, addr=1, data=0xA5 -> req0_ready=1 one cycle. Two edges later q1=0xA5, q0=0, wr_done=1 with wr_src=0 for exactly one cycle.
- Contention: both valid from reset, req0 addr0 0x11, req1 addr1 0x22, both held after accept with new data -> grant order 0,1,0,1. Writes complete every 2 cycles. q0=0x11 then q1=0x22.
- Same-register overwrite: req0 writes 0x33 to addr0, then req1 writes 0x44 to addr0 -> q0=0x33 then 0x44. q1 unchanged.
- Reset mid-write: accept req1 0x7E to addr0, assert rst in the WRITE cycle -> q0=0, no wr_done, next arbitration favours req0.
- ARB_LOCK_EN: req0 three locked transfers while req1 valid -> req1_ready=0 until req0 sends lock=0. Then req1 is granted next.
